lisnoc_dma_target_r2l_resp: RTL



---
 rtl/lisnoc_dma_target_r2l_resp_if.sv | 52 +++++
 rtl/lisnoc_dma_target_r2l_resp.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/lisnoc_dma_target_r2l_resp_if.sv
// Handshake and bus bundle of the R2L response DMA: request input, NoC output,
// Wishbone read master and completion report. master = DMA side, slave = environment side.
interface lisnoc_dma_target_r2l_resp_if #(
  parameter int FLIT_WIDTH = 34,
  parameter int DEST_WIDTH = 5,
  parameter int ID_WIDTH   = 2
);
  logic                  req_valid;
  logic                  req_ready;
  logic [DEST_WIDTH-1:0] req_dest;
  logic [ID_WIDTH-1:0]   req_id;
  logic [31:0]           req_laddr;
  logic [31:0]           req_raddr;
  logic [31:0]           req_size;

  logic [FLIT_WIDTH-1:0] noc_out_flit;
  logic                  noc_out_valid;
  logic                  noc_out_ready;

  logic                  wb_cyc_o;
  logic                  wb_stb_o;
  logic                  wb_we_o;
  logic [31:0]           wb_adr_o;
  logic [2:0]            wb_cti_o;
  logic [1:0]            wb_bte_o;
  logic [3:0]            wb_sel_o;
  logic                  wb_ack_i;
  logic [31:0]           wb_dat_i;

  logic                  done_en;
  logic [ID_WIDTH-1:0]   done_id;

  modport master (
    input  req_valid, req_dest, req_id, req_laddr, req_raddr, req_size,
    output req_ready,
    output noc_out_flit, noc_out_valid,
    input  noc_out_ready,
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_cti_o, wb_bte_o, wb_sel_o,
    input  wb_ack_i, wb_dat_i,
    output done_en, done_id
  );

  modport slave (
    output req_valid, req_dest, req_id, req_laddr, req_raddr, req_size,
    input  req_ready,
    input  noc_out_flit, noc_out_valid,
    output noc_out_ready,
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_cti_o, wb_bte_o, wb_sel_o,
    output wb_ack_i, wb_dat_i,
    input  done_en, done_id
  );
endinterface

// File: rtl/lisnoc_dma_target_r2l_resp.sv
// Target-side R2L read responder: bursts up to D words from local memory over Wishbone,
// then emits them as one R2L_RESP packet (header, address, data); repeats until the request is done.
module lisnoc_dma_target_r2l_resp #(
  parameter int NOC_PACKET_SIZE = 16
) (
  input logic                          clk,
  input logic                          rst,
  lisnoc_dma_target_r2l_resp_if.master io_bus
);
  localparam int D  = NOC_PACKET_SIZE - 2;
  localparam int CW = $clog2(D + 1);

  localparam logic [1:0] FT_PAYLOAD = 2'b00;
  localparam logic [1:0] FT_HEADER  = 2'b01;
  localparam logic [1:0] FT_LAST    = 2'b10;
  localparam logic [1:0] PT_R2L_RESP = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_WB_READ, S_SEND_HDR, S_SEND_ADDR, S_SEND_DATA
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [4:0]  r_dest;
  logic [1:0]  r_id;
  logic [31:0] r_laddr;
  logic [31:0] r_raddr;
  logic [31:0] r_remaining;
  logic [CW-1:0] r_cnt;
  logic [31:0] r_buf [D];

  logic [CW-1:0] w_chunk;
  logic          w_cnt_last;
  logic          w_pkt_last;
  logic [1:0]    w_ftype;
  logic [31:0]   w_content;

  assign w_chunk    = (r_remaining < 32'(D)) ? r_remaining[CW-1:0] : CW'(D);
  assign w_cnt_last = (r_cnt == w_chunk - CW'(1));
  assign w_pkt_last = (r_remaining == 32'(w_chunk));

  always_comb begin
    w_next                = r_state;
    w_ftype               = FT_PAYLOAD;
    w_content             = '0;
    io_bus.req_ready      = 1'b0;
    io_bus.noc_out_valid  = 1'b0;
    io_bus.wb_cyc_o       = 1'b0;
    io_bus.wb_stb_o       = 1'b0;
    io_bus.wb_we_o        = 1'b0;
    io_bus.wb_adr_o       = '0;
    io_bus.wb_cti_o       = 3'b000;
    io_bus.wb_bte_o       = 2'b00;
    io_bus.wb_sel_o       = 4'hf;
    io_bus.done_en        = 1'b0;
    io_bus.done_id        = '0;
    // Outputs are forced to their idle values for the whole reset cycle.
    if (!rst) begin
      unique case (r_state)
        S_IDLE: begin
          io_bus.req_ready = 1'b1;
          if (io_bus.req_valid) begin
            if (io_bus.req_size == 32'd0) begin
              io_bus.done_en = 1'b1;
              io_bus.done_id = io_bus.req_id;
            end else begin
              w_next = S_WB_READ;
            end
          end
        end
        S_WB_READ: begin
          io_bus.wb_cyc_o = 1'b1;
          io_bus.wb_stb_o = 1'b1;
          io_bus.wb_adr_o = r_laddr;
          io_bus.wb_cti_o = w_cnt_last ? 3'b111 : 3'b010;
          if (io_bus.wb_ack_i && w_cnt_last) w_next = S_SEND_HDR;
        end
        S_SEND_HDR: begin
          io_bus.noc_out_valid = 1'b1;
          w_ftype              = FT_HEADER;
          w_content[31:27]     = r_dest;
          w_content[23:22]     = PT_R2L_RESP;
          w_content[20]        = w_pkt_last;
          w_content[19:18]     = r_id;
          if (io_bus.noc_out_ready) w_next = S_SEND_ADDR;
        end
        S_SEND_ADDR: begin
          io_bus.noc_out_valid = 1'b1;
          w_content            = r_raddr;
          if (io_bus.noc_out_ready) w_next = S_SEND_DATA;
        end
        S_SEND_DATA: begin
          io_bus.noc_out_valid = 1'b1;
          w_ftype              = w_cnt_last ? FT_LAST : FT_PAYLOAD;
          w_content            = r_buf[r_cnt];
          if (io_bus.noc_out_ready && w_cnt_last) begin
            if (w_pkt_last) begin
              io_bus.done_en = 1'b1;
              io_bus.done_id = r_id;
              w_next         = S_IDLE;
            end else begin
              w_next = S_WB_READ;
            end
          end
        end
        default: w_next = S_IDLE;
      endcase
    end
    io_bus.noc_out_flit = {w_ftype, w_content};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_dest      <= '0;
      r_id        <= '0;
      r_laddr     <= '0;
      r_raddr     <= '0;
      r_remaining <= '0;
      r_cnt       <= '0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        S_IDLE: if (io_bus.req_valid) begin
          r_dest      <= io_bus.req_dest;
          r_id        <= io_bus.req_id;
          r_laddr     <= io_bus.req_laddr;
          r_raddr     <= io_bus.req_raddr;
          r_remaining <= io_bus.req_size;
          r_cnt       <= '0;
        end
        S_WB_READ: if (io_bus.wb_ack_i) begin
          r_laddr <= r_laddr + 32'd4;
          r_cnt   <= r_cnt + CW'(1);
        end
        S_SEND_ADDR: if (io_bus.noc_out_ready) r_cnt <= '0;
        S_SEND_DATA: if (io_bus.noc_out_ready) begin
          if (w_cnt_last) begin
            r_remaining <= r_remaining - 32'(w_chunk);
            r_raddr     <= r_raddr + 32'({w_chunk, 2'b00});
            r_cnt       <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && r_state == S_WB_READ && io_bus.wb_ack_i) r_buf[r_cnt] <= io_bus.wb_dat_i;
  end
endmodule
